// File: rtl/data_mem_pkg.sv
// Shared encodings for the multi-cycle data-memory responder.
// Holds the state/op enums and the legal range of the access latency.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int CNT_W       = 4;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

endpackage

// File: rtl/latency_counter.sv
// Loadable 4-bit down-counter timing the BUSY phase of an access.
// zero reports the count after this cycle's update, so the caller can leave BUSY on that edge.
module latency_counter
    import data_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the memory stage: one request at a time, Stall while
// in flight, a one-cycle Done pulse with read data, err on malformed requests.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 8,
    parameter int LATENCY        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        Halt,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    localparam int WORDS = 1 << MEM_WORDS_LOG2;

    state_e                    state_q, state_d;
    op_e                       op_q, op_d;
    logic [MEM_WORDS_LOG2-1:0] idx_q, idx_d;
    logic [15:0]               wdata_q, wdata_d;
    logic [15:0]               dout_q, dout_d;
    logic                      done_q, done_d;
    logic                      stall_q, stall_d;
    logic                      err_q, err_d;
    logic [15:0]               mem_q [WORDS];

    logic can_accept, accept, illegal;
    logic cnt_load, cnt_dec, cnt_zero;
    logic mem_we;

    // Word index wraps: address bits above the array size are don't-care.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[15:MEM_WORDS_LOG2+1];

    latency_counter u_latency_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(LATENCY - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        can_accept = (state_q != BUSY) && !Halt;
        accept     = can_accept && (Rd ^ Wr) && !Addr[0];
        illegal    = can_accept && (Rd | Wr) && ((Rd & Wr) || Addr[0]);

        case (state_q)
            BUSY: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    op_d     = Wr ? OP_WR : OP_RD;
                    idx_d    = Addr[MEM_WORDS_LOG2:1];
                    wdata_d  = DataIn;
                    cnt_load = 1'b1;
                    state_d  = (LATENCY > 1) ? BUSY : DONE;
                end
            end
        endcase

        // A write lands on the edge entering DONE, so a read accepted in that DONE cycle sees it.
        mem_we  = (state_d == DONE) && (op_d == OP_WR);
        dout_d  = ((state_d == DONE) && (op_d == OP_RD)) ? mem_q[idx_d] : '0;
        done_d  = (state_d == DONE);
        stall_d = (state_d == BUSY);
        err_d   = illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            if (mem_we) mem_q[idx_d] <= wdata_d;
        end
    end

    assign DataOut = dout_q;
    assign Done    = done_q;
    assign Stall   = stall_q;
    assign err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=4 and LATENCY=1 instances checked every cycle
// against a transaction-level model, plus hand-computed literal expectations.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i  [2];
    logic [15:0] addr_i [2];
    logic [15:0] din_i  [2];
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic        halt_i [2];
    logic [15:0] dout_o [2];
    logic        done_o [2];
    logic        stall_o[2];
    logic        err_o  [2];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    data_mem_responder #(.MEM_WORDS_LOG2(8), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst_i[0]), .Addr(addr_i[0]), .DataIn(din_i[0]),
        .Rd(rd_i[0]), .Wr(wr_i[0]), .Halt(halt_i[0]),
        .DataOut(dout_o[0]), .Done(done_o[0]), .Stall(stall_o[0]), .err(err_o[0])
    );

    data_mem_responder #(.MEM_WORDS_LOG2(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst_i[1]), .Addr(addr_i[1]), .DataIn(din_i[1]),
        .Rd(rd_i[1]), .Wr(wr_i[1]), .Halt(halt_i[1]),
        .DataOut(dout_o[1]), .Done(done_o[1]), .Stall(stall_o[1]), .err(err_o[1])
    );

    // Model: cycle-numbered transactions. An accept at the end of cycle n completes in
    // cycle n+L; the unit is free again from that cycle on.
    int          n = 0;
    bit          pend    [2];
    int          done_at [2];
    int          err_at  [2] = '{-1, -1};
    bit          m_rd    [2];
    int          m_idx   [2];
    logic [15:0] m_dat   [2];
    logic [15:0] mm      [2][256];

    function automatic int lat(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_i[k]) begin
                pend[k]   = 1'b0;
                err_at[k] = -1;
                for (int a = 0; a < 256; a++) mm[k][a] = 16'h0000;
            end else if (!pend[k] || n >= done_at[k]) begin
                if (!halt_i[k] && (rd_i[k] || wr_i[k])) begin
                    if ((rd_i[k] && wr_i[k]) || addr_i[k][0]) begin
                        err_at[k] = n + 1;
                    end else begin
                        pend[k]    = 1'b1;
                        done_at[k] = n + lat(k);
                        m_rd[k]    = rd_i[k];
                        m_idx[k]   = int'(addr_i[k][8:1]);
                        m_dat[k]   = din_i[k];
                    end
                end
            end
        end
        n++;
        for (int k = 0; k < 2; k++)
            if (!rst_i[k] && pend[k] && !m_rd[k] && n == done_at[k]) mm[k][m_idx[k]] = m_dat[k];
    end

    task automatic check(string nm, int k, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] t=%0t: got %h, expected %h", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic        e_done, e_stall, e_err;
                logic [15:0] e_dout;
                e_done  = pend[k] && (n == done_at[k]);
                e_stall = pend[k] && (n < done_at[k]);
                e_err   = (n == err_at[k]);
                e_dout  = (e_done && m_rd[k]) ? mm[k][m_idx[k]] : 16'h0000;
                check("Done",    k, 16'(done_o[k]),  16'(e_done));
                check("Stall",   k, 16'(stall_o[k]), 16'(e_stall));
                check("err",     k, 16'(err_o[k]),   16'(e_err));
                check("DataOut", k, dout_o[k],       e_dout);
            end
        end
    end

    task automatic step(int c);
        repeat (c) @(negedge clk);
    endtask

    // Present a request for one cycle; returns in cycle 1 relative to the request.
    task automatic issue(int k, logic rd, logic wr, logic [15:0] a, logic [15:0] d);
        rd_i[k]   = rd;
        wr_i[k]   = wr;
        addr_i[k] = a;
        din_i[k]  = d;
        @(negedge clk);
        rd_i[k]   = 1'b0;
        wr_i[k]   = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_i[k] = 1'b1; addr_i[k] = '0; din_i[k] = '0;
            rd_i[k] = 1'b0; wr_i[k] = 1'b0; halt_i[k] = 1'b0;
        end
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_Done", 0, 16'(done_o[0]), 16'h0);
        check("rst_DataOut", 0, dout_o[0], 16'h0);
        step(1);
        rst_i[0] = 1'b0; rst_i[1] = 1'b0;
        step(1);

        // Read after reset
        issue(0, 1, 0, 16'h0010, 16'h0);
        check("rd_stall_c1", 0, 16'(stall_o[0]), 16'h1);
        step(2);
        check("rd_stall_c3", 0, 16'(stall_o[0]), 16'h1);
        step(1);
        check("rd_done_c4", 0, 16'(done_o[0]), 16'h1);
        check("rd_data_c4", 0, dout_o[0], 16'h0000);

        // Write then read in the write's DONE cycle
        step(1);
        issue(0, 0, 1, 16'h0020, 16'hBEEF);
        step(3);
        check("wr_done_c4", 0, 16'(done_o[0]), 16'h1);
        issue(0, 1, 0, 16'h0020, 16'h0);
        step(3);
        check("raw_done", 0, 16'(done_o[0]), 16'h1);
        check("raw_data", 0, dout_o[0], 16'hBEEF);

        // Illegal requests
        step(1);
        issue(0, 1, 0, 16'h0021, 16'h0);
        check("odd_err", 0, 16'(err_o[0]), 16'h1);
        check("odd_stall", 0, 16'(stall_o[0]), 16'h0);
        step(1);
        check("odd_err_clr", 0, 16'(err_o[0]), 16'h0);
        issue(0, 1, 1, 16'h0022, 16'h0);
        check("rdwr_err", 0, 16'(err_o[0]), 16'h1);
        check("rdwr_stall", 0, 16'(stall_o[0]), 16'h0);
        step(2);

        // Halt raised mid-write, then a held request under Halt
        issue(0, 0, 1, 16'h0030, 16'h1234);
        step(1);
        halt_i[0] = 1'b1;
        step(2);
        check("halt_done_c4", 0, 16'(done_o[0]), 16'h1);
        rd_i[0] = 1'b1; addr_i[0] = 16'h0030;
        step(3);
        check("halt_no_stall", 0, 16'(stall_o[0]), 16'h0);
        check("halt_no_err", 0, 16'(err_o[0]), 16'h0);
        rd_i[0] = 1'b0; halt_i[0] = 1'b0;
        step(1);
        issue(0, 1, 0, 16'h0030, 16'h0);
        step(3);
        check("halt_wr_data", 0, dout_o[0], 16'h1234);

        // Reset in the middle of a write
        step(1);
        issue(0, 0, 1, 16'h0040, 16'hAAAA);
        step(1);
        rst_i[0] = 1'b1;
        step(1);
        check("mid_rst_done", 0, 16'(done_o[0]), 16'h0);
        check("mid_rst_stall", 0, 16'(stall_o[0]), 16'h0);
        rst_i[0] = 1'b0;
        step(2);
        issue(0, 1, 0, 16'h0040, 16'h0);
        step(3);
        check("mid_rst_rd_done", 0, 16'(done_o[0]), 16'h1);
        check("mid_rst_rd_data", 0, dout_o[0], 16'h0000);
        issue(0, 1, 0, 16'h0020, 16'h0);
        step(3);
        check("rst_cleared_data", 0, dout_o[0], 16'h0000);

        // LATENCY=1: no stall, back-to-back write then aliased read
        step(1);
        issue(1, 1, 0, 16'h0010, 16'h0);
        check("l1_rd_done", 1, 16'(done_o[1]), 16'h1);
        check("l1_rd_stall", 1, 16'(stall_o[1]), 16'h0);
        issue(1, 0, 1, 16'h0202, 16'h5555);
        check("l1_wr_done", 1, 16'(done_o[1]), 16'h1);
        issue(1, 1, 0, 16'h0002, 16'h0);
        check("alias_done", 1, 16'(done_o[1]), 16'h1);
        check("alias_data", 1, dout_o[1], 16'h5555);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
